// File: rtl/gpio_input_conditioner_pkg.sv
// gpio_cond_pkg: shared constants for the gpioA input conditioner.
package gpio_cond_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 120000;

    localparam int GPIOA_VALUE_LSB = 0;
    localparam int GPIOA_RISE_LSB  = 8;
    localparam int GPIOA_FALL_LSB  = 16;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: synchroniser, counter debounce and sticky edge flags for one pin.
module gpio_debounce_bit
    import gpio_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    input  logic clear_rise,
    input  logic clear_fall,
    output logic value,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d, s2_q, s2_d, stable_q, stable_d;
    logic             rise_q, rise_d, fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             differ, accept;

    always_comb begin
        s1_d     = pin;
        s2_d     = s1_q;
        differ   = s2_q != stable_q;
        accept   = differ && (cnt_q == LAST);
        // any sample matching the stable level restarts the count
        cnt_d    = (differ && !accept) ? cnt_q + CNT_W'(1) : '0;
        stable_d = accept ? s2_q : stable_q;
        rise_d   = (accept && s2_q) || (rise_q && !clear_rise);
        fall_d   = (accept && !s2_q) || (fall_q && !clear_fall);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign value = stable_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: per-bit debounced levels and sticky edge flags for gpioA inputs.
module gpio_input_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             io_mainClk,
    input  logic             io_resetn,
    input  logic [WIDTH-1:0] io_pins,
    input  logic [WIDTH-1:0] io_clear_rise,
    input  logic [WIDTH-1:0] io_clear_fall,
    output logic [WIDTH-1:0] io_value,
    output logic [WIDTH-1:0] io_rise,
    output logic [WIDTH-1:0] io_fall,
    output logic             io_irq
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("DEBOUNCE_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk       (io_mainClk),
            .rst_n     (io_resetn),
            .pin       (io_pins[i]),
            .clear_rise(io_clear_rise[i]),
            .clear_fall(io_clear_fall[i]),
            .value     (io_value[i]),
            .rise      (io_rise[i]),
            .fall      (io_fall[i])
        );
    end

    assign io_irq = |{io_rise, io_fall};

endmodule
